// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: two requesters share one 4-op ALU (AND/OR/ADD/SUB).
// Round-robin arbitration picks a winner whenever the single-entry result
// slot is free. The winner's result is registered with a carry/borrow flag
// and the requester id. A consumer drains the slot with valid/ready.
// A saturating counter per requester tracks accepted ops.
module alu_rr_scheduler #(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             v0,
  input  logic [1:0]       op0,
  input  logic [W-1:0]     a0,
  input  logic [W-1:0]     b0,
  output logic             rdy0,
  input  logic             v1,
  input  logic [1:0]       op1,
  input  logic [W-1:0]     a1,
  input  logic [W-1:0]     b1,
  output logic             rdy1,
  output logic             res_valid,
  output logic [W-1:0]     res,
  output logic             res_carry,
  output logic             res_id,
  input  logic             res_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  // prio_reg: requester favoured when both ask (0 after reset)
  logic             prio_reg;
  logic             res_valid_reg;
  logic [W-1:0]     res_reg;
  logic             res_carry_reg;
  logic             res_id_reg;
  logic [CNT_W-1:0] cnt_reg [2];

  logic             slot_free;
  logic             gnt0;
  logic             gnt1;
  logic             any_gnt;
  logic [1:0]       gnt_vec;
  logic [1:0]       sel_op;
  logic [W-1:0]     sel_a;
  logic [W-1:0]     sel_b;
  logic [W:0]       alu_wide;

  // Arbitration: accept only when the slot is empty or being drained now
  always_comb begin
    slot_free = !res_valid_reg || res_ready;
    gnt0      = slot_free && v0 && (!v1 || !prio_reg);
    gnt1      = slot_free && v1 && (!v0 || prio_reg);
    any_gnt   = gnt0 || gnt1;
    gnt_vec   = {gnt1, gnt0};
  end

  // Operand mux and ALU in W+1 bits; bit W is carry (ADD) or borrow (SUB)
  always_comb begin
    sel_op   = gnt1 ? op1 : op0;
    sel_a    = gnt1 ? a1  : a0;
    sel_b    = gnt1 ? b1  : b0;
    alu_wide = '0;
    case (sel_op)
      2'b00:   alu_wide = {1'b0, sel_a & sel_b};
      2'b01:   alu_wide = {1'b0, sel_a | sel_b};
      2'b10:   alu_wide = {1'b0, sel_a} + {1'b0, sel_b};
      default: alu_wide = {1'b0, sel_a} - {1'b0, sel_b};
    endcase
  end

  // Result slot: load on grant (overwrites a draining entry), clear valid on drain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_valid_reg <= 1'b0;
      res_reg       <= '0;
      res_carry_reg <= 1'b0;
      res_id_reg    <= 1'b0;
    end else if (any_gnt) begin
      res_valid_reg <= 1'b1;
      res_reg       <= alu_wide[W-1:0];
      res_carry_reg <= alu_wide[W];
      res_id_reg    <= gnt1;
    end else if (res_ready) begin
      res_valid_reg <= 1'b0;
    end
  end

  // Round-robin pointer: favour the requester that did not just win
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_reg <= 1'b0;
    end else if (any_gnt) begin
      prio_reg <= gnt0;
    end
  end

  // Per-requester saturating accept counters
  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    // Count each accept of this requester, holding at all-ones
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_reg[gi] <= '0;
      end else if (gnt_vec[gi] && (cnt_reg[gi] != {CNT_W{1'b1}})) begin
        cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
      end
    end
  end

  assign rdy0      = gnt0;
  assign rdy1      = gnt1;
  assign res_valid = res_valid_reg;
  assign res       = res_reg;
  assign res_carry = res_carry_reg;
  assign res_id    = res_id_reg;
  assign cnt0      = cnt_reg[0];
  assign cnt1      = cnt_reg[1];

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Bench for alu_rr_scheduler: directed scenarios followed by random traffic.
// The driver predicts grants and results from the arbitration rules and pushes
// expected results into a queue; a monitor compares whatever the slot shows.
// A second instance with 2-bit counters shares the inputs to exercise saturation.
module tb_alu_rr_scheduler;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         v0 = 1'b0, v1 = 1'b0;
  logic [1:0]   op0 = '0, op1 = '0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic         res_ready = 1'b0;

  logic         rdy0, rdy1, res_valid, res_carry, res_id;
  logic [W-1:0] res;
  logic [7:0]   cnt0, cnt1;

  logic         rdy0_s, rdy1_s, res_valid_s, res_carry_s, res_id_s;
  logic [W-1:0] res_s;
  logic [1:0]   cnt0_s, cnt1_s;

  alu_rr_scheduler #(.W(W), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .v0(v0), .op0(op0), .a0(a0), .b0(b0), .rdy0(rdy0),
    .v1(v1), .op1(op1), .a1(a1), .b1(b1), .rdy1(rdy1),
    .res_valid(res_valid), .res(res), .res_carry(res_carry), .res_id(res_id),
    .res_ready(res_ready), .cnt0(cnt0), .cnt1(cnt1)
  );

  alu_rr_scheduler #(.W(W), .CNT_W(2)) dut_s (
    .clk(clk), .reset(reset),
    .v0(v0), .op0(op0), .a0(a0), .b0(b0), .rdy0(rdy0_s),
    .v1(v1), .op1(op1), .a1(a1), .b1(b1), .rdy1(rdy1_s),
    .res_valid(res_valid_s), .res(res_s), .res_carry(res_carry_s), .res_id(res_id_s),
    .res_ready(res_ready), .cnt0(cnt0_s), .cnt1(cnt1_s)
  );

  always #5 clk = ~clk;

  typedef struct { int r; int c; int id; } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;

  // reference state
  bit m_valid = 0;
  int last_winner = 1;     // so the first contended grant goes to 0
  int m_cnt0 = 0, m_cnt1 = 0;
  bit last_g0 = 0, last_g1 = 0;
  logic seen_rdy0, seen_rdy1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t alu_ref(input int op, input int a, input int b, input int id);
    exp_t e;
    int m = 2 ** W;
    e.id = id;
    case (op)
      0: begin e.r = a & b; e.c = 0; end
      1: begin e.r = a | b; e.c = 0; end
      2: begin e.r = (a + b) % m; e.c = (a + b >= m) ? 1 : 0; end
      default: begin e.r = (a - b + m) % m; e.c = (a < b) ? 1 : 0; end
    endcase
    return e;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // One clock of stimulus: drive, predict the grant, check, update the model
  task automatic step(input logic iv0, input logic [1:0] iop0, input logic [W-1:0] ia0,
                      input logic [W-1:0] ib0, input logic iv1, input logic [1:0] iop1,
                      input logic [W-1:0] ia1, input logic [W-1:0] ib1, input logic irr);
    bit free, g0, g1;
    @(negedge clk);
    v0 = iv0; op0 = iop0; a0 = ia0; b0 = ib0;
    v1 = iv1; op1 = iop1; a1 = ia1; b1 = ib1;
    res_ready = irr;
    #1;
    free = !m_valid || irr;
    g0 = 0; g1 = 0;
    if (free) begin
      if (iv0 && iv1) begin
        if (last_winner == 0) g1 = 1; else g0 = 1;
      end else if (iv0) g0 = 1;
      else if (iv1) g1 = 1;
    end
    seen_rdy0 = rdy0; seen_rdy1 = rdy1;
    chk("rdy0", 32'(rdy0), 32'(g0));
    chk("rdy1", 32'(rdy1), 32'(g1));
    chk("res_valid", 32'(res_valid), 32'(m_valid));
    chk("cnt0", 32'(cnt0), 32'(sat(m_cnt0, 255)));
    chk("cnt1", 32'(cnt1), 32'(sat(m_cnt1, 255)));
    chk("cnt0_sat", 32'(cnt0_s), 32'(sat(m_cnt0, 3)));
    if (g0) begin
      exp_q.push_back(alu_ref(int'(iop0), int'(ia0), int'(ib0), 0));
      last_winner = 0; m_cnt0++;
    end
    if (g1) begin
      exp_q.push_back(alu_ref(int'(iop1), int'(ia1), int'(ib1), 1));
      last_winner = 1; m_cnt1++;
    end
    m_valid = g0 || g1 || (m_valid && !irr);
    last_g0 = g0; last_g1 = g1;
  endtask

  // Assert reset away from any edge, while inputs are parked idle
  task automatic do_reset(input bit check_now);
    @(negedge clk);
    #3;
    v0 = 0; v1 = 0; res_ready = 0;
    reset = 1'b1;
    #1;
    if (check_now) begin
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_res", 32'(res), 32'd0);
      chk("rst_res_carry", 32'(res_carry), 32'd0);
      chk("rst_res_id", 32'(res_id), 32'd0);
      chk("rst_cnt0", 32'(cnt0), 32'd0);
      chk("rst_cnt1", 32'(cnt1), 32'd0);
    end
    exp_q.delete();
    m_valid = 0; last_winner = 1; m_cnt0 = 0; m_cnt1 = 0;
    last_g0 = 0; last_g1 = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: compare the presented slot with the scoreboard head, pop on drain
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!reset && res_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL scoreboard_empty actual=res_valid=1 expected=no_result t=%0t", $time);
        end else begin
          e = exp_q[0];
          chk("mon_res", 32'(res), 32'(e.r));
          chk("mon_carry", 32'(res_carry), 32'(e.c));
          chk("mon_id", 32'(res_id), 32'(e.id));
          if (res_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  logic [W-1:0] t2_res [4] = '{4'b1000, 4'b1111, 4'b0111, 4'b0011};
  logic         t2_c   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  int           t6_cnt [5] = '{1, 2, 3, 3, 3};

  initial begin
    logic [W-1:0] held_res;
    logic         held_id;
    logic nv0, nv1;
    logic [1:0] nop0, nop1;
    logic [W-1:0] na0, nb0, na1, nb1;

    reset = 1'b1;
    repeat (2) @(negedge clk);
    #3;
    chk("init_res_valid", 32'(res_valid), 32'd0);
    chk("init_cnt0", 32'(cnt0), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // single requester, all four ops, full rate
    for (int i = 0; i < 4; i++) begin
      step(1, 2'(i), 4'b1101, 4'b1010, 0, 2'b00, 4'd0, 4'd0, 1);
      @(posedge clk); #1;
      chk("t2_res", 32'(res), 32'(t2_res[i]));
      chk("t2_carry", 32'(res_carry), 32'(t2_c[i]));
      chk("t2_id", 32'(res_id), 32'd0);
    end
    chk("t2_cnt0", 32'(cnt0), 32'd4);

    // SUB with borrow from requester 1
    step(0, 2'b00, 4'd0, 4'd0, 1, 2'b11, 4'b1010, 4'b1101, 1);
    @(posedge clk); #1;
    chk("t5_res", 32'(res), 32'b1101);
    chk("t5_carry", 32'(res_carry), 32'd1);
    chk("t5_id", 32'(res_id), 32'd1);

    // hold the slot, then reset mid-hold
    step(1, 2'b10, 4'd3, 4'd4, 0, 2'b00, 4'd0, 4'd0, 0);
    step(1, 2'b10, 4'd3, 4'd4, 0, 2'b00, 4'd0, 4'd0, 0);
    chk("t1_holding", 32'(res_valid), 32'd1);
    do_reset(1);

    // contention from reset: alternating grants starting with 0
    for (int i = 0; i < 6; i++) begin
      step(1, 2'b10, 4'(i), 4'd1, 1, 2'b11, 4'(i), 4'd2, 1);
      chk("t3_rdy0", 32'(seen_rdy0), 32'((i % 2) == 0));
      chk("t3_rdy1", 32'(seen_rdy1), 32'((i % 2) == 1));
    end
    @(posedge clk); #1;
    chk("t3_cnt0", 32'(cnt0), 32'd3);
    chk("t3_cnt1", 32'(cnt1), 32'd3);

    // backpressure: drain, one accept, hold, then release
    step(0, 2'b00, 4'd0, 4'd0, 0, 2'b00, 4'd0, 4'd0, 1);
    step(1, 2'b01, 4'd5, 4'd9, 1, 2'b10, 4'd7, 4'd12, 0);
    @(posedge clk); #1;
    held_res = res; held_id = res_id;
    step(1, 2'b01, 4'd5, 4'd9, 1, 2'b10, 4'd7, 4'd12, 0);
    step(1, 2'b01, 4'd5, 4'd9, 1, 2'b10, 4'd7, 4'd12, 0);
    chk("t4_hold_res", 32'(res), 32'(held_res));
    chk("t4_hold_id", 32'(res_id), 32'(held_id));
    step(1, 2'b01, 4'd5, 4'd9, 1, 2'b10, 4'd7, 4'd12, 1);
    chk("t4_regrant_other", 32'(seen_rdy1), 32'(held_id == 1'b0));

    // counter saturation on the 2-bit instance
    do_reset(0);
    for (int i = 0; i < 5; i++) begin
      step(1, 2'b00, 4'd15, 4'd15, 0, 2'b00, 4'd0, 4'd0, 1);
      @(posedge clk); #1;
      chk("t6_cnt0_sat", 32'(cnt0_s), 32'(t6_cnt[i]));
    end

    // random traffic; pending requests stay put until accepted or withdrawn
    for (int i = 0; i < 400; i++) begin
      nv0 = v0; nop0 = op0; na0 = a0; nb0 = b0;
      nv1 = v1; nop1 = op1; na1 = a1; nb1 = b1;
      if (v0 && !last_g0) begin
        if ($urandom_range(0, 7) == 0) nv0 = 0;
      end else begin
        nv0 = 1'($urandom_range(0, 1)); nop0 = 2'($urandom_range(0, 3));
        na0 = 4'($urandom_range(0, 15)); nb0 = 4'($urandom_range(0, 15));
      end
      if (v1 && !last_g1) begin
        if ($urandom_range(0, 7) == 0) nv1 = 0;
      end else begin
        nv1 = 1'($urandom_range(0, 1)); nop1 = 2'($urandom_range(0, 3));
        na1 = 4'($urandom_range(0, 15)); nb1 = 4'($urandom_range(0, 15));
      end
      step(nv0, nop0, na0, nb0, nv1, nop1, na1, nb1, ($urandom_range(0, 3) != 0));
    end
    step(0, 2'b00, 4'd0, 4'd0, 0, 2'b00, 4'd0, 4'd0, 1);
    step(0, 2'b00, 4'd0, 4'd0, 0, 2'b00, 4'd0, 4'd0, 1);
    @(negedge clk); #3;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
